// File: rtl/nv_ram_fifo_ctrl_128x60_if.sv
// nv_ram_fifo_ctrl_128x60_if: bundles the write stream, read stream, RAM port
// and occupancy signals of the FIFO controller.
// slave  : the controller side.
// master : the surrounding producer/consumer/RAM side.
interface nv_ram_fifo_ctrl_128x60_if #(
  parameter int AW = 7,
  parameter int DW = 60
);
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_di;
  logic          ram_re;
  logic [AW-1:0] ram_ra;
  logic [DW-1:0] ram_dout;
  logic [AW:0]   fifo_cnt;

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy, ram_dout,
    output wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di,
           ram_re, ram_ra, fifo_cnt
  );

  modport master (
    output wr_pvld, wr_pd, rd_prdy, ram_dout,
    input  wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di,
           ram_re, ram_ra, fifo_cnt
  );
endinterface

// File: rtl/nv_ram_fifo_ctrl_128x60.sv
// nv_ram_fifo_ctrl_128x60: valid/ready FIFO controller around a 128x60
// two-port RAM with 1-cycle registered read, plus a 2-entry output buffer
// so the read side sustains one transfer per cycle.
// Optional feature macro: NV_RAM_FIFO_BYPASS_EN -- when defined, a write that
// arrives with nothing older in the RAM or in flight goes straight into the
// output buffer (1-cycle latency instead of 3).
module nv_ram_fifo_ctrl_128x60 #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 60
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  nv_ram_fifo_ctrl_128x60_if.slave    bus
);

  localparam logic [AW:0]   L_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] L_PTR_ONE = AW'(1);

  logic          r_ready;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_ram_cnt;
  logic          r_infl;
  logic [1:0]    r_out_cnt;
  logic [DW-1:0] r_buf0;
  logic [DW-1:0] r_buf1;

  logic          w_accept;
  logic          w_pop;
  logic          w_issue;
  logic          w_bypass;
  logic          w_ram_wr;
  logic          w_push;
  logic [DW-1:0] w_push_data;

  assign w_accept = bus.wr_pvld & bus.wr_prdy;
  assign w_pop    = (r_out_cnt != 2'd0) & bus.rd_prdy;
  // Only issue a RAM read when its data is guaranteed a buffer slot on arrival.
  assign w_issue  = (r_ram_cnt != '0) &
                    (({1'b0, r_out_cnt} + {2'b00, r_infl}) < (3'd2 + {2'b00, w_pop}));

`ifdef NV_RAM_FIFO_BYPASS_EN
  // Bypass only with no older data in RAM or in flight, so ordering holds.
  assign w_bypass = w_accept & (r_ram_cnt == '0) & ~r_infl &
                    ({1'b0, r_out_cnt} < (3'd2 + {2'b00, w_pop}));
`else
  assign w_bypass = 1'b0;
`endif

  assign w_ram_wr    = w_accept & ~w_bypass;
  assign w_push      = r_infl | w_bypass;
  // r_infl and w_bypass are mutually exclusive (bypass requires !r_infl).
  assign w_push_data = r_infl ? bus.ram_dout : bus.wr_pd;

  assign bus.wr_prdy  = r_ready & (r_ram_cnt != L_FULL);
  assign bus.ram_we   = w_ram_wr;
  assign bus.ram_wa   = r_wr_ptr;
  assign bus.ram_di   = bus.wr_pd;
  assign bus.ram_re   = w_issue;
  assign bus.ram_ra   = r_rd_ptr;
  assign bus.rd_pvld  = (r_out_cnt != 2'd0);
  assign bus.rd_pd    = r_buf0;
  assign bus.fifo_cnt = r_ram_cnt + (AW+1)'(r_infl) + (AW+1)'(r_out_cnt);

  // Control state: pointers, occupancy counts, in-flight flag, ready flop.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_ready   <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_infl    <= 1'b0;
      r_out_cnt <= 2'd0;
    end else begin
      r_ready <= 1'b1;
      r_infl  <= w_issue;
      if (w_ram_wr) r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
      if (w_issue)  r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      case ({w_ram_wr, w_issue})
        2'b10:   r_ram_cnt <= r_ram_cnt + L_CNT_ONE;
        2'b01:   r_ram_cnt <= r_ram_cnt - L_CNT_ONE;
        default: r_ram_cnt <= r_ram_cnt;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_out_cnt <= r_out_cnt + 2'd1;
        2'b01:   r_out_cnt <= r_out_cnt - 2'd1;
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

  // Output buffer data: head in r_buf0, shifted forward on pop.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_push && w_pop) begin
      if (r_out_cnt == 2'd1) begin
        r_buf0 <= w_push_data;
      end else begin
        r_buf0 <= r_buf1;
        r_buf1 <= w_push_data;
      end
    end else if (w_push) begin
      if (r_out_cnt == 2'd0) r_buf0 <= w_push_data;
      else                   r_buf1 <= w_push_data;
    end else if (w_pop) begin
      r_buf0 <= r_buf1;
    end
  end

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_128x60.sv
// Directed bench for nv_ram_fifo_ctrl_128x60 with a behavioural 128x60 RAM
// and an in-order queue model of accepted-but-not-popped words.
module tb_nv_ram_fifo_ctrl_128x60;

`ifdef NV_RAM_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 1;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  nv_ram_fifo_ctrl_128x60_if #(.AW(7), .DW(60)) bus ();

  nv_ram_fifo_ctrl_128x60 #(.DEPTH(128), .AW(7), .DW(60)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .bus             (bus)
  );

  logic [59:0] mem [128];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_wa] <= bus.ram_di;
    if (bus.ram_re) bus.ram_dout <= mem[bus.ram_ra];
  end

  int          n_total = 0;
  int          n_bad   = 0;
  longint      cyc     = 0;
  longint      out_cyc = 0;
  int          n_pop   = 0;
  logic [59:0] q[$];
  bit          hold_prev = 1'b0;
  bit          mon_en    = 1'b0;
  logic [6:0]  m_wp = 7'd0;
  logic [6:0]  m_rp = 7'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic mon();
    logic acc;
    acc = bus.wr_pvld & bus.wr_prdy;
    chk("cnt", 64'(bus.fifo_cnt), 64'(q.size()));
    if (bus.rd_pvld) begin
      if (q.size() == 0) chk("pvld_empty", 64'(bus.rd_pvld), 64'd0);
      else               chk("data", 64'(bus.rd_pd), 64'(q[0]));
    end
    if (hold_prev) chk("hold_vld", 64'(bus.rd_pvld), 64'd1);
    if (bus.ram_we) begin
      chk("wa", 64'(bus.ram_wa), 64'(m_wp));
      chk("di", 64'(bus.ram_di), 64'(bus.wr_pd));
      m_wp = m_wp + 7'd1;
    end
    if (bus.ram_re) begin
      chk("ra", 64'(bus.ram_ra), 64'(m_rp));
      m_rp = m_rp + 7'd1;
    end
    if (bus.rd_pvld && bus.rd_prdy && q.size() != 0) begin
      void'(q.pop_front());
      n_pop++;
      out_cyc = cyc;
    end
    if (acc) q.push_back(bus.wr_pd);
    hold_prev = bus.rd_pvld & ~bus.rd_prdy;
  endtask

  task automatic step();
    sample();
    if (mon_en) mon();
    adv();
  endtask

  task automatic reset_model();
    q.delete();
    m_wp = 7'd0;
    m_rp = 7'd0;
    hold_prev = 1'b0;
  endtask

  task automatic write_n(input int cnt, input int base);
    int acc_n;
    int n;
    acc_n = 0;
    n = 0;
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 60'(base);
    while (acc_n < cnt && n < 400) begin
      sample();
      if (bus.wr_pvld && bus.wr_prdy) acc_n++;
      mon();
      adv();
      bus.wr_pd = 60'(base + acc_n);
      n++;
    end
    chk("wr_acc", 64'(acc_n), 64'(cnt));
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.wr_pvld = 1'b0;
    bus.rd_prdy = 1'b1;
    while (q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    longint t0;
    int     p0;
    int     sent;
    int     n;
    int     wraps;
    logic   acc;
    logic [63:0] r64;

    rstn        = 1'b0;
    bus.wr_pvld = 1'b0;
    bus.wr_pd   = '0;
    bus.rd_prdy = 1'b0;
    repeat (2) adv();

    // reset values
    sample();
    chk("rst_prdy", 64'(bus.wr_prdy), 64'd0);
    chk("rst_pvld", 64'(bus.rd_pvld), 64'd0);
    chk("rst_we",   64'(bus.ram_we),  64'd0);
    chk("rst_re",   64'(bus.ram_re),  64'd0);
    chk("rst_wa",   64'(bus.ram_wa),  64'd0);
    chk("rst_ra",   64'(bus.ram_ra),  64'd0);
    chk("rst_cnt",  64'(bus.fifo_cnt), 64'd0);
    adv();
    rstn = 1'b1;
    sample();
    chk("rdy_first", 64'(bus.wr_prdy), 64'd0);
    adv();
    sample();
    chk("rdy_up", 64'(bus.wr_prdy), 64'd1);
    adv();
    mon_en = 1'b1;

    // single write latency
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 60'hABC;
    bus.rd_prdy = 1'b1;
    t0 = cyc;
    p0 = n_pop;
    sample();
    chk("w1_we", 64'(bus.ram_we), BYP ? 64'd0 : 64'd1);
    chk("w1_wa", 64'(bus.ram_wa), 64'd0);
    mon();
    adv();
    bus.wr_pvld = 1'b0;
    sample();
    chk("w1_re", 64'(bus.ram_re), BYP ? 64'd0 : 64'd1);
    mon();
    adv();
    repeat (5) step();
    chk("w1_pops", 64'(n_pop - p0), 64'd1);
    chk("w1_lat", 64'(out_cyc - t0), 64'(LAT));
    sample();
    chk("w1_cnt", 64'(bus.fifo_cnt), 64'd0);
    mon();
    adv();

    // fill to 130 with the consumer stalled
    bus.rd_prdy = 1'b0;
    write_n(130, 256);
    sample();
    chk("full_rdy", 64'(bus.wr_prdy), 64'd0);
    chk("full_cnt", 64'(bus.fifo_cnt), 64'd130);
    chk("full_re",  64'(bus.ram_re), 64'd0);
    mon();
    adv();
    repeat (3) step();
    bus.wr_pvld = 1'b0;

    // one pop frees a RAM slot via the issue it triggers
    bus.rd_prdy = 1'b1;
    sample();
    chk("pop_re",   64'(bus.ram_re), 64'd1);
    chk("pop_rdy0", 64'(bus.wr_prdy), 64'd0);
    mon();
    adv();
    bus.rd_prdy = 1'b0;
    sample();
    chk("pop_rdy1", 64'(bus.wr_prdy), 64'd1);
    chk("pop_cnt",  64'(bus.fifo_cnt), 64'd129);
    mon();
    adv();
    sample();
    chk("pop_rdy2", 64'(bus.wr_prdy), 64'd1);
    mon();
    adv();
    drain();
    repeat (2) step();

    // continuous streaming, no bubbles after the first output
    p0 = n_pop;
    sent = 0;
    n = 0;
    bus.wr_pvld = 1'b1;
    bus.rd_prdy = 1'b1;
    bus.wr_pd   = 60'(5000);
    while ((n_pop - p0) < 1000 && n < 1300) begin
      sample();
      if ((n_pop - p0) > 0) chk("nogap", 64'(bus.rd_pvld), 64'd1);
      if (sent < 1000)      chk("st_rdy", 64'(bus.wr_prdy), 64'd1);
      acc = bus.wr_pvld & bus.wr_prdy;
      mon();
      if (acc) sent++;
      adv();
      bus.wr_pvld = (sent < 1000);
      bus.wr_pd   = 60'(5000 + sent);
      n++;
    end
    chk("st_done", 64'(n_pop - p0), 64'd1000);
    bus.wr_pvld = 1'b0;
    repeat (2) step();

    // random valid/ready traffic
    p0 = n_pop;
    sent = 0;
    n = 0;
    wraps = 0;
    r64 = {$urandom(), $urandom()};
    bus.wr_pd = r64[59:0];
    while ((n_pop - p0) < 5000 && n < 40000) begin
      bus.wr_pvld = (sent < 5000) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.rd_prdy = 1'($urandom_range(0, 1));
      sample();
      acc = bus.wr_pvld & bus.wr_prdy;
      if (bus.ram_re && bus.ram_ra == 7'd127) wraps++;
      mon();
      adv();
      if (acc) begin
        sent++;
        r64 = {$urandom(), $urandom()};
        bus.wr_pd = r64[59:0];
      end
      n++;
    end
    chk("rnd_done", 64'(n_pop - p0), 64'd5000);
    chk("rnd_wrap", 64'(wraps >= (BYP ? 1 : 30)), 64'd1);
    drain();
    repeat (2) step();

    // reset with 40 entries queued
    bus.rd_prdy = 1'b0;
    write_n(40, 9000);
    bus.wr_pvld = 1'b0;
    repeat (3) step();
    sample();
    chk("q40_cnt", 64'(bus.fifo_cnt), 64'd40);
    mon();
    adv();
    mon_en = 1'b0;
    rstn = 1'b0;
    adv();
    rstn = 1'b1;
    reset_model();
    sample();
    chk("rst2_pvld", 64'(bus.rd_pvld), 64'd0);
    chk("rst2_cnt",  64'(bus.fifo_cnt), 64'd0);
    chk("rst2_rdy",  64'(bus.wr_prdy), 64'd0);
    adv();
    sample();
    chk("rst2_rdy1", 64'(bus.wr_prdy), 64'd1);
    adv();
    mon_en = 1'b1;
    p0 = n_pop;
    bus.rd_prdy = 1'b1;
    write_n(5, 12000);
    drain();
    repeat (4) step();
    chk("rst2_new", 64'(n_pop - p0), 64'd5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
